// File: rtl/worker_pipe_if.sv
// Packet-in / result-out handshake bundle for worker_pipe.
// The master side feeds packets and consumes results; the slave side is the worker.
interface worker_pipe_if #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned COLOR_WIDTH = 16,
   parameter int unsigned INSN_WIDTH  = 4
);
   localparam int unsigned DEST_WIDTH   = 3 + ADDR_WIDTH;
   localparam int unsigned PACKET_WIDTH = 2 + INSN_WIDTH + 4*DATA_WIDTH + DEST_WIDTH + COLOR_WIDTH;
   localparam int unsigned RESULT_WIDTH = DEST_WIDTH + COLOR_WIDTH + DATA_WIDTH;

   logic                    PC_VALID;
   logic                    PC_READY;
   logic [PACKET_WIDTH-1:0] PC_DATA;
   logic                    WR_VALID;
   logic                    WR_READY;
   logic [RESULT_WIDTH-1:0] WR_DATA;
   logic                    ERR_INSN;

   modport master (
      output PC_VALID, PC_DATA, WR_READY,
      input  PC_READY, WR_VALID, WR_DATA, ERR_INSN
   );

   modport slave (
      input  PC_VALID, PC_DATA, WR_READY,
      output PC_READY, WR_VALID, WR_DATA, ERR_INSN
   );
endinterface

// File: rtl/worker_pipe.sv
// Dataflow worker: executes one matched packet, queues 0-3 tagged results in a FIFO.
// Define WORKER_PIPE_MUL_EN to enable opcode 7 (MUL); otherwise opcode 7 is unknown.
module worker_pipe #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned COLOR_WIDTH = 16,
   parameter int unsigned INSN_WIDTH  = 4,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic         CLK,
   input  logic         RST,
   worker_pipe_if.slave bus
);
   localparam int unsigned DEST_WIDTH   = 3 + ADDR_WIDTH;
   localparam int unsigned PACKET_WIDTH = 2 + INSN_WIDTH + 4*DATA_WIDTH + DEST_WIDTH + COLOR_WIDTH;
   localparam int unsigned RESULT_WIDTH = DEST_WIDTH + COLOR_WIDTH + DATA_WIDTH;
   localparam int unsigned PTR_WIDTH    = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_WIDTH    = PTR_WIDTH + 1;
   localparam int unsigned PAD_WIDTH    = DATA_WIDTH - DEST_WIDTH;

   // Packet field offsets, LSB upward
   localparam int unsigned DEST_LSB = COLOR_WIDTH;
   localparam int unsigned D4_LSB   = DEST_LSB + DEST_WIDTH;
   localparam int unsigned D3_LSB   = D4_LSB + DATA_WIDTH;
   localparam int unsigned D2_LSB   = D3_LSB + DATA_WIDTH;
   localparam int unsigned D1_LSB   = D2_LSB + DATA_WIDTH;
   localparam int unsigned OP_LSB   = D1_LSB + DATA_WIDTH;
   localparam int unsigned TAG_LSB  = OP_LSB + INSN_WIDTH;

   localparam logic [INSN_WIDTH-1:0] OP_DIST   = INSN_WIDTH'(0);
   localparam logic [INSN_WIDTH-1:0] OP_SWITCH = INSN_WIDTH'(1);
   localparam logic [INSN_WIDTH-1:0] OP_SETC   = INSN_WIDTH'(2);
   localparam logic [INSN_WIDTH-1:0] OP_SYNC   = INSN_WIDTH'(3);
   localparam logic [INSN_WIDTH-1:0] OP_PLUS   = INSN_WIDTH'(4);
   localparam logic [INSN_WIDTH-1:0] OP_MINUS  = INSN_WIDTH'(5);
   localparam logic [INSN_WIDTH-1:0] OP_LT     = INSN_WIDTH'(6);
   localparam logic [INSN_WIDTH-1:0] OP_MUL    = INSN_WIDTH'(7);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t                  state_q, state_d;
   logic [1:0]              k_q, k_d, n_q, n_d;
   logic [PACKET_WIDTH-1:0] pkt_q;
   logic                    push, pop, accept, err_d;

   logic [RESULT_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_WIDTH-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
   logic [CNT_WIDTH-1:0]    count_q, count_d;
   logic [RESULT_WIDTH-1:0] push_data, head_d;

   logic                    pc_ready_q, wr_valid_q, err_q;
   logic [RESULT_WIDTH-1:0] wr_data_q;

   // Latched packet fields
   logic                    tag0;
   logic [INSN_WIDTH-1:0]   opcode;
   logic [DATA_WIDTH-1:0]   d1, d2;
   logic [DEST_WIDTH-1:0]   d2_dest, d3_dest, d4_dest, pkt_dest;
   logic [COLOR_WIDTH-1:0]  pkt_color;
   logic                    unused_pkt_bits;

   assign tag0      = pkt_q[TAG_LSB];
   assign opcode    = pkt_q[OP_LSB +: INSN_WIDTH];
   assign d1        = pkt_q[D1_LSB +: DATA_WIDTH];
   assign d2        = pkt_q[D2_LSB +: DATA_WIDTH];
   assign d2_dest   = pkt_q[D2_LSB +: DEST_WIDTH];
   assign d3_dest   = pkt_q[D3_LSB +: DEST_WIDTH];
   assign d4_dest   = pkt_q[D4_LSB +: DEST_WIDTH];
   assign pkt_dest  = pkt_q[DEST_LSB +: DEST_WIDTH];
   assign pkt_color = pkt_q[COLOR_WIDTH-1:0];

   // Upper bits of destination-only words and tag[1] carry no meaning
   assign unused_pkt_bits = ^{pkt_q[TAG_LSB+1],
                              pkt_q[D3_LSB+DEST_WIDTH +: PAD_WIDTH],
                              pkt_q[D4_LSB+DEST_WIDTH +: PAD_WIDTH]};

   assign accept = bus.PC_VALID && pc_ready_q;
   assign pop    = wr_valid_q && bus.WR_READY;

   assign bus.PC_READY = pc_ready_q;
   assign bus.WR_VALID = wr_valid_q;
   assign bus.WR_DATA  = wr_data_q;
   assign bus.ERR_INSN = err_q;

   // Number of results an opcode produces
   function automatic logic [1:0] op_len(input logic [INSN_WIDTH-1:0] op, input logic t0);
      case (op)
         OP_DIST:   return t0 ? 2'd3 : 2'd2;
         OP_SYNC:   return 2'd2;
         OP_SWITCH,
         OP_SETC,
         OP_PLUS,
         OP_MINUS,
         OP_LT:     return 2'd1;
`ifdef WORKER_PIPE_MUL_EN
         OP_MUL:    return 2'd1;
`endif
         default:   return 2'd0;
      endcase
   endfunction

   // Next-state: one result per cycle in EMIT, unknown opcode flagged and dropped
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      n_d     = n_q;
      push    = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = EMIT;
               k_d     = 2'd0;
               n_d     = op_len(bus.PC_DATA[OP_LSB +: INSN_WIDTH], bus.PC_DATA[TAG_LSB]);
            end
         end
         EMIT: begin
            if (n_q == 2'd0) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               push = 1'b1;
               k_d  = k_q + 2'd1;
               if (k_q == n_q - 2'd1) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Result k of the latched packet
   always_comb begin
      logic [DEST_WIDTH-1:0]  res_dest;
      logic [COLOR_WIDTH-1:0] res_color;
      logic [DATA_WIDTH-1:0]  res_data;
      res_dest  = pkt_dest;
      res_color = pkt_color;
      res_data  = d1;
      case (opcode)
         OP_DIST: begin
            case (k_q)
               2'd0:    res_dest = d2_dest;
               2'd1:    res_dest = d3_dest;
               default: res_dest = d4_dest;
            endcase
         end
         OP_SWITCH: res_dest  = (d2 != '0) ? d3_dest : d4_dest;
         OP_SETC:   res_color = d2[COLOR_WIDTH-1:0];
         OP_SYNC: begin
            if (k_q == 2'd0) begin
               res_dest = d3_dest;
            end else begin
               res_dest = d4_dest;
               res_data = d2;
            end
         end
         OP_PLUS:   res_data = d1 + d2;
         OP_MINUS:  res_data = d1 - d2;
         OP_LT:     res_data = DATA_WIDTH'(d1 < d2);
`ifdef WORKER_PIPE_MUL_EN
         OP_MUL:    res_data = d1 * d2;
`endif
         default: ;
      endcase
      push_data = {res_dest, res_color, res_data};
   end

   // FIFO bookkeeping; next head bypasses the write when it lands on the new head slot
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (pop) rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_WIDTH'(1);
         2'b01:   count_d = count_q - CNT_WIDTH'(1);
         default: count_d = count_q;
      endcase
      head_d = (push && (wr_ptr_q == rd_ptr_d)) ? push_data : mem[rd_ptr_d];
   end

   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr_q] <= push_data;
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q    <= IDLE;
         k_q        <= 2'd0;
         n_q        <= 2'd0;
         pkt_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         pc_ready_q <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_data_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         n_q      <= n_d;
         if (accept) pkt_q <= bus.PC_DATA;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         // Room for the largest burst (3) before the next packet may enter
         pc_ready_q <= (state_d == IDLE) && (count_d <= CNT_WIDTH'(FIFO_DEPTH - 3));
         wr_valid_q <= (count_d != '0);
         if (count_d != '0) wr_data_q <= head_d;
         err_q <= err_d;
      end
   end
endmodule

// File: tb/tb_worker_pipe.sv
// Scoreboard bench for worker_pipe: driver queues expected results, monitor checks pops.
// Honours WORKER_PIPE_MUL_EN in the same way as the design.
module tb_worker_pipe;
   logic CLK;
   logic RST;

   worker_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .COLOR_WIDTH(16), .INSN_WIDTH(4)) bus();

   worker_pipe #(
      .DATA_WIDTH(32), .ADDR_WIDTH(16), .COLOR_WIDTH(16), .INSN_WIDTH(4), .FIFO_DEPTH(4)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          last_acc = 0;
   int          rdy_mode = 0;
   logic [66:0] exp_q[$];
   bit          err_at[int];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: results a packet must produce, computed directly from opcode semantics
   task automatic model(input logic [1:0] tag, input logic [3:0] op,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] d3, input logic [31:0] d4,
                        input logic [18:0] dest, input logic [15:0] color, input int e);
      logic [18:0] t2, t3, t4;
      logic [31:0] r;
      t2 = d2[18:0];
      t3 = d3[18:0];
      t4 = d4[18:0];
      case (op)
         4'd0: begin
            exp_q.push_back({t2, color, d1});
            exp_q.push_back({t3, color, d1});
            if (tag[0]) exp_q.push_back({t4, color, d1});
         end
         4'd1: exp_q.push_back({(d2 != 32'd0) ? t3 : t4, color, d1});
         4'd2: exp_q.push_back({dest, d2[15:0], d1});
         4'd3: begin
            exp_q.push_back({t3, color, d1});
            exp_q.push_back({t4, color, d2});
         end
         4'd4: begin r = d1 + d2; exp_q.push_back({dest, color, r}); end
         4'd5: begin r = d1 - d2; exp_q.push_back({dest, color, r}); end
         4'd6: begin r = (d1 < d2) ? 32'd1 : 32'd0; exp_q.push_back({dest, color, r}); end
`ifdef WORKER_PIPE_MUL_EN
         4'd7: begin r = d1 * d2; exp_q.push_back({dest, color, r}); end
`endif
         default: err_at[e + 1] = 1'b1;
      endcase
   endtask

   // Present one packet; called and returns at posedge+1
   task automatic send(input logic [1:0] tag, input logic [3:0] op,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] d3, input logic [31:0] d4,
                       input logic [18:0] dest, input logic [15:0] color);
      int waited;
      waited = 0;
      bus.PC_DATA  = {tag, op, d1, d2, d3, d4, dest, color};
      bus.PC_VALID = 1'b1;
      @(negedge CLK);
      while (!bus.PC_READY && waited < 500) begin
         waited++;
         @(negedge CLK);
      end
      if (!bus.PC_READY) begin
         vectors++;
         miscompares++;
         $display("FAIL accept_timeout: op %0d never accepted, PC_READY=%b required 1", op, bus.PC_READY);
      end else begin
         last_acc = cyc + 1;
         model(tag, op, d1, d2, d3, d4, dest, color, last_acc);
      end
      @(posedge CLK);
      #1;
      bus.PC_VALID = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 2000) begin
         @(posedge CLK);
         w++;
      end
      #1;
      chk("drain_empty", 67'(exp_q.size()), 67'd0);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Consumer ready: 0 low, 1 high, other random
   initial begin
      bus.WR_READY = 1'b0;
      forever begin
         @(posedge CLK);
         #1;
         case (rdy_mode)
            0:       bus.WR_READY = 1'b0;
            1:       bus.WR_READY = 1'b1;
            default: bus.WR_READY = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: ERR_INSN timing and result order
   always @(negedge CLK) begin
      logic [66:0] e;
      logic        exp_err;
      if (RST) begin
         exp_err = err_at.exists(cyc) ? 1'b1 : 1'b0;
         chk("err_insn", 67'(bus.ERR_INSN), 67'(exp_err));
         if (bus.WR_VALID && bus.WR_READY) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_result: got %h required none", bus.WR_DATA);
            end else begin
               e = exp_q.pop_front();
               chk("result", bus.WR_DATA, e);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      int acc[6];
      RST          = 1'b0;
      bus.PC_VALID = 1'b0;
      bus.PC_DATA  = '0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_pc_ready", 67'(bus.PC_READY), 67'd0);
      chk("rst_wr_valid", 67'(bus.WR_VALID), 67'd0);
      chk("rst_wr_data", bus.WR_DATA, 67'd0);
      chk("rst_err", 67'(bus.ERR_INSN), 67'd0);
      tick();
      RST = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      chk("post_rst_pc_ready", 67'(bus.PC_READY), 67'd1);
      chk("post_rst_wr_valid", 67'(bus.WR_VALID), 67'd0);
      tick();

      // Reset in the middle of a 3-way DISTRIBUTE
      send(2'b01, 4'd0, 32'hdeadbeef, {13'd0, 3'd2, 16'hdead}, {13'd0, 3'd5, 16'hbeef},
           {13'd0, 3'd7, 16'h0001}, 19'd0, 16'h0f0f);
      tick();
      tick();
      @(negedge CLK);
      chk("mid_wr_valid", 67'(bus.WR_VALID), 67'd1);
      tick();
      RST = 1'b0;
      exp_q.delete();
      err_at.delete();
      @(posedge CLK);
      @(negedge CLK);
      chk("midrst_wr_valid", 67'(bus.WR_VALID), 67'd0);
      chk("midrst_pc_ready", 67'(bus.PC_READY), 67'd0);
      chk("midrst_wr_data", bus.WR_DATA, 67'd0);
      tick();
      RST = 1'b1;
      tick();

      // Directed opcodes
      rdy_mode = 1;
      send(2'b01, 4'd0, 32'hdeadbeef, {13'd0, 3'd2, 16'hdead}, {13'd0, 3'd5, 16'hbeef},
           {13'd0, 3'd7, 16'h0001}, 19'd0, 16'h0f0f);
      send(2'b00, 4'd1, 32'h1234abcd, 32'd1, {13'd0, 3'd0, 16'h0f0f}, {13'd0, 3'd7, 16'hf0f0},
           19'h12345, 16'h0001);
      send(2'b00, 4'd1, 32'h1234abcd, 32'd0, {13'd0, 3'd0, 16'h0f0f}, {13'd0, 3'd7, 16'hf0f0},
           19'h12345, 16'h0001);
      send(2'b00, 4'd2, 32'h11112222, 32'h0000badc, 32'd0, 32'd0, {3'd3, 16'h4444}, 16'habcd);
      send(2'b00, 4'd4, 32'hdead0000, 32'h0000beef, 32'd0, 32'd0, {3'd1, 16'h0010}, 16'h0202);
      send(2'b00, 4'd5, 32'd0, 32'd1, 32'd0, 32'd0, {3'd6, 16'h0020}, 16'h0303);
      send(2'b00, 4'd6, 32'd3, 32'd5, 32'd0, 32'd0, {3'd4, 16'h0030}, 16'h0404);
      send(2'b00, 4'd6, 32'd5, 32'd3, 32'd0, 32'd0, {3'd4, 16'h0031}, 16'h0405);
      send(2'b00, 4'd7, 32'h00010003, 32'h00020005, 32'd0, 32'd0, {3'd2, 16'h0040}, 16'h0505);
      send(2'b11, 4'd9, 32'h1, 32'h2, 32'h3, 32'h4, {3'd2, 16'h0050}, 16'h0606);
      drain();

      // Backpressure: two SYNCs with the consumer stalled
      rdy_mode = 0;
      tick();
      tick();
      send(2'b00, 4'd3, 32'haaaa0001, 32'hbbbb0002, {13'd0, 3'd1, 16'h1111}, {13'd0, 3'd2, 16'h2222},
           19'd0, 16'h0707);
      tick();
      tick();
      tick();
      @(negedge CLK);
      chk("bp_pc_ready", 67'(bus.PC_READY), 67'd0);
      chk("bp_wr_valid", 67'(bus.WR_VALID), 67'd1);
      tick();
      rdy_mode = 1;
      send(2'b00, 4'd3, 32'hcccc0003, 32'hdddd0004, {13'd0, 3'd3, 16'h3333}, {13'd0, 3'd4, 16'h4444},
           19'd0, 16'h0808);
      drain();

      // Back-to-back PLUS: one accept every 2 cycles
      for (int i = 0; i < 6; i++) begin
         send(2'b00, 4'd4, 32'($urandom), 32'($urandom), 32'd0, 32'd0, 19'(i), 16'(i));
         acc[i] = last_acc;
      end
      for (int i = 1; i < 6; i++) chk("plus_rate", 67'(acc[i] - acc[i-1]), 67'd2);
      drain();

      // Randomised traffic with random backpressure
      rdy_mode = 2;
      for (int i = 0; i < 200; i++) begin
         logic [3:0]  op;
         logic [31:0] a, b;
         op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
         a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : 32'($urandom);
         b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : 32'($urandom);
         if ($urandom_range(0, 5) == 0) b = 32'd0;
         send(2'($urandom), op, a, b, 32'($urandom), 32'($urandom), 19'($urandom), 16'($urandom));
         repeat ($urandom_range(0, 2)) tick();
      end
      rdy_mode = 1;
      drain();
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/worker_pipe.md
Name: worker_pipe

Overview:
Parametrised successor of the dataflow worker. Accepts one matched packet per handshake, executes its instruction, and pushes 0–3 tagged results (dest option, dest addr, color, data) into an internal result FIFO. The FIFO drains to the router over a valid/ready port. The worker can accept the next packet while earlier results are still draining. Adds 3-way DISTRIBUTE, MINUS, LT and an unknown-opcode flag.

Parameters:
DATA_WIDTH, 32, operand/result data width
ADDR_WIDTH, 16, destination address width
COLOR_WIDTH, 16, color (context tag) width
INSN_WIDTH, 4, opcode width
FIFO_DEPTH, 4, result FIFO entries; power of 2, >=4
Derived: DEST_WIDTH=3+ADDR_WIDTH; PACKET_WIDTH=2+INSN_WIDTH+4*DATA_WIDTH+DEST_WIDTH+COLOR_WIDTH; RESULT_WIDTH=DEST_WIDTH+COLOR_WIDTH+DATA_WIDTH

Ports:
CLK  in  1  clock
RST  in  1  synchronous, active-low reset
PC_VALID  in  1  packet valid
PC_READY  out  1  worker can accept packet
PC_DATA  in  PACKET_WIDTH  MSB→LSB: tag[1:0], opcode, data1, data2, data3, data4, dest_option[2:0], dest_addr, color
WR_VALID  out  1  FIFO head valid
WR_READY  in  1  consumer ready
WR_DATA  out  RESULT_WIDTH  {dest_option, dest_addr, color, data}
ERR_INSN  out  1  one-cycle pulse: unknown opcode dropped

Behaviour:
- Reset: when RST=0 at a rising edge, all state is cleared: FSM→IDLE, FIFO emptied, PC_READY=0, WR_VALID=0, WR_DATA=0, ERR_INSN=0. Reset mid-operation discards latched packets and queued results.
- Handshakes: a transfer occurs on an edge where VALID&&READY. Data must be held stable while VALID=1 and READY=0.
- PC_READY=1 only when the FSM is IDLE and the FIFO has at least 3 free entries. This prevents FIFO overflow; a push to a full FIFO is impossible by construction.
- Accept edge E: the packet is latched and the FSM moves to EMIT with k=0 and n set by the opcode. One result is pushed per edge at E+1 … E+n. FSM returns to IDLE at edge E+n. n=0 returns to IDLE at E+1.
- Destination words: low DEST_WIDTH bits of a data word = {option, addr}; upper bits are ignored.
- Opcodes (n, results):
  - 0 DISTRIBUTE: n=2+tag[0]. data1 is sent to the dests in data2, data3, and data4 if tag[0]=1. Color unchanged.
  - 1 SWITCH: n=1. data1 goes to the data3 dest if data2!=0, otherwise to the data4 dest.
  - 2 SET_COLOR: n=1. data1 goes to the packet dest with color=data2[COLOR_WIDTH-1:0].
  - 3 SYNC: n=2. data1 goes to the data3 dest, then data2 goes to the data4 dest.
  - 4 PLUS: n=1. data1+data2 (mod 2^DATA_WIDTH) goes to the packet dest.
  - 5 MINUS: n=1. data1-data2 (mod 2^DATA_WIDTH) goes to the packet dest.
  - 6 LT: n=1. Unsigned data1<data2 yields 1, else 0, zero-extended, to the packet dest.
  - others: n=0. ERR_INSN is high for the single cycle after edge E+1.
- Result ordering: FIFO order equals emit order. Packets complete in acceptance order.
- FIFO: circular read/write pointers plus a count. Simultaneous push and pop leaves the count unchanged. A pop when empty is impossible because WR_VALID=0. WR_DATA is the head entry, registered, and stable while WR_VALID=1 and WR_READY=0.
- Throughput: with WR_READY held high, n=1 ops sustain one packet per 2 cycles. First WR_VALID is visible after edge E+1.

Optional Feature:
WORKER_PIPE_MUL_EN: when defined, opcode 7 MUL has n=1 and sends the low DATA_WIDTH bits of data1*data2 to the packet dest. When undefined, opcode 7 is unknown: dropped, ERR_INSN pulses.

Test Plan:
- Reset then RST=1: PC_READY=1 and WR_VALID=0 within 1 cycle. Assert RST=0 mid-DISTRIBUTE: FIFO empties, WR_VALID=0 on the next edge.
- DISTRIBUTE tag=01, data1=deadbeef, dests {2,dead},{5,beef},{7,0001}, color 0f0f → three results in order, each carrying deadbeef with color 0f0f.
- SWITCH data1=1234abcd: with data2=1 it goes to {0,0f0f}; with data2=0 it goes to {7,f0f0}. SET_COLOR old=abcd, data2=badc → result color=badc.
- PLUS dead0000+0000beef=deadbeef; MINUS 0-1=ffffffff; LT 3<5 → 1 and 5<3 → 0. Opcode 7 gives MUL per macro, or ERR_INSN plus no result.
- Backpressure: WR_READY=0 while sending SYNC then SYNC. PC_READY drops once free entries <3, and no result is lost or reordered after WR_READY=1.
- Back-to-back PLUS with WR_READY=1: one accept per 2 cycles; a simultaneous push/pop keeps the count correct.
